// File: rtl/cga_vram_arbiter.sv
// CPU-side VRAM port for the CGA core: captures ISA framebuffer reads/writes and runs each
// one in a free sequencer slot, holding the bus in wait states until the access completes.
module cga_vram_arbiter #(
    parameter bit          USE_BUS_WAIT = 1'b1,
    parameter int unsigned RAM_LATENCY  = 1,
    parameter logic [14:0] VRAM_MASK    = 15'h3FFF,
    parameter logic [7:0]  SLOT_TIMEOUT = 8'd40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] bus_a,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic [7:0]  bus_d,
    input  logic        bus_mem_cs,
    input  logic        isa_op_enable,
    input  logic [18:0] disp_ram_a,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_wd,
    input  logic [7:0]  ram_d,
    output logic [7:0]  bus_out_mem,
    output logic        bus_dir_mem,
    output logic        bus_rdy,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSlot,
        StAccess,
        StLatch,
        StDone
    } state_e;

    localparam logic LatLast = (RAM_LATENCY > 1) ? 1'b1 : 1'b0;

    state_e      state_q, state_d;
    logic        memr_meta_q, memr_s_q, memw_meta_q, memw_s_q;
    logic        strb_prev_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        lat_cnt_q, lat_cnt_d;
    logic [14:0] lat_a_q, lat_a_d;
    logic [7:0]  lat_d_q, lat_d_d;
    logic        lat_wr_q, lat_wr_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_rdy_q, bus_rdy_d;

    logic        strb_all;
    logic        req;
    logic [7:0]  wait_inc;

    assign strb_all = memr_s_q & memw_s_q;
    assign req      = strb_prev_q & ~strb_all & bus_mem_cs;
    assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        lat_a_d    = lat_a_q;
        lat_d_d    = lat_d_q;
        lat_wr_d   = lat_wr_q;
        bus_out_d  = bus_out_q;
        bus_rdy_d  = bus_rdy_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d    = StWaitSlot;
                    lat_a_d    = bus_a;
                    lat_d_d    = bus_d;
                    // A write strobe wins when both fall together.
                    lat_wr_d   = ~memw_s_q;
                    wait_cnt_d = 8'd0;
                    bus_rdy_d  = 1'b0;
                end
            end
            StWaitSlot: begin
                if (isa_op_enable) begin
                    state_d = StAccess;
                end else if (wait_inc >= SLOT_TIMEOUT) begin
                    // Forced completion: reads return all-ones, writes are dropped.
                    state_d   = StDone;
                    bus_rdy_d = 1'b1;
                    if (!lat_wr_q) begin
                        bus_out_d = 8'hFF;
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            StAccess: begin
                if (lat_wr_q) begin
                    state_d   = StDone;
                    bus_rdy_d = 1'b1;
                end else begin
                    state_d   = StLatch;
                    lat_cnt_d = 1'b0;
                end
            end
            StLatch: begin
                if (lat_cnt_q == LatLast) begin
                    state_d   = StDone;
                    bus_out_d = ram_d;
                    bus_rdy_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (strb_all) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memr_meta_q <= 1'b1;
            memr_s_q    <= 1'b1;
            memw_meta_q <= 1'b1;
            memw_s_q    <= 1'b1;
            strb_prev_q <= 1'b1;
            state_q     <= StIdle;
            wait_cnt_q  <= 8'd0;
            lat_cnt_q   <= 1'b0;
            lat_a_q     <= 15'd0;
            lat_d_q     <= 8'd0;
            lat_wr_q    <= 1'b0;
            bus_out_q   <= 8'd0;
            bus_rdy_q   <= 1'b1;
        end else begin
            memr_meta_q <= bus_memr_l;
            memr_s_q    <= memr_meta_q;
            memw_meta_q <= bus_memw_l;
            memw_s_q    <= memw_meta_q;
            strb_prev_q <= strb_all;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            lat_a_q     <= lat_a_d;
            lat_d_q     <= lat_d_d;
            lat_wr_q    <= lat_wr_d;
            bus_out_q   <= bus_out_d;
            bus_rdy_q   <= bus_rdy_d;
        end
    end

    // The CPU owns the RAM only in its ACCESS cycle; display fetches see it otherwise.
    assign ram_a       = (state_q == StAccess) ? {4'h0, lat_a_q & VRAM_MASK} : disp_ram_a;
    assign ram_we_l    = ~((state_q == StAccess) & lat_wr_q);
    assign ram_wd      = lat_d_q;
    assign bus_out_mem = bus_out_q;
    assign bus_dir_mem = bus_mem_cs & ~bus_memr_l;
    assign bus_rdy     = USE_BUS_WAIT ? bus_rdy_q : 1'b1;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Self-checking bench for cga_vram_arbiter: table vectors, randomized transactions against a
// transaction-level model with a RAM array, and a reset-during-access sequence.
module tb_cga_vram_arbiter;

    localparam logic [14:0] Mask    = 15'h3FFF;
    localparam int          Timeout = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] bus_a;
    logic        bus_memr_l, bus_memw_l;
    logic [7:0]  bus_d;
    logic        bus_mem_cs;
    logic        isa_op_enable;
    logic [18:0] disp_ram_a;
    logic [18:0] ram_a;
    logic        ram_we_l;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_d;
    logic [7:0]  bus_out_mem;
    logic        bus_dir_mem;
    logic        bus_rdy;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    cga_vram_arbiter #(
        .USE_BUS_WAIT(1'b1),
        .RAM_LATENCY (2),
        .VRAM_MASK   (Mask),
        .SLOT_TIMEOUT(8'd40)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_a        (bus_a),
        .bus_memr_l   (bus_memr_l),
        .bus_memw_l   (bus_memw_l),
        .bus_d        (bus_d),
        .bus_mem_cs   (bus_mem_cs),
        .isa_op_enable(isa_op_enable),
        .disp_ram_a   (disp_ram_a),
        .ram_a        (ram_a),
        .ram_we_l     (ram_we_l),
        .ram_wd       (ram_wd),
        .ram_d        (ram_d),
        .bus_out_mem  (bus_out_mem),
        .bus_dir_mem  (bus_dir_mem),
        .bus_rdy      (bus_rdy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(int i);
        return 8'(i) ^ 8'h3C;
    endfunction

    // RAM model: two-stage read pipeline (latency 2), synchronous write.
    logic [7:0]  mem [0:32767];
    logic [14:0] a_p1, a_p2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32768; i++) mem[i] <= pat(i);
            mem[15'h1FFF] <= 8'h5A;
        end else if (!ram_we_l) begin
            mem[ram_a[14:0]] <= ram_wd;
        end
        a_p1 <= ram_a[14:0];
        a_p2 <= a_p1;
    end
    assign ram_d = mem[a_p2];

    logic [7:0] ref_mem [0:32767];
    logic [7:0] model_out;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_xact(input bit r, input bit w, input logic [14:0] a, input logic [7:0] d,
                            input int j, output int rdy_low, output int we_cnt,
                            output int disp_mis, output logic [18:0] we_a,
                            output logic [7:0] we_d, output bit done_busy, output bit idle_ok);
        rdy_low  = 0;
        we_cnt   = 0;
        disp_mis = 0;
        we_a     = '0;
        we_d     = '0;
        @(negedge clk);
        bus_a         = a;
        bus_d         = d;
        bus_mem_cs    = 1'b1;
        bus_memr_l    = ~r;
        bus_memw_l    = ~w;
        isa_op_enable = 1'b0;
        disp_ram_a    = {1'b1, 18'($urandom)};
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!bus_rdy) rdy_low++;
            if (!ram_we_l) begin
                we_cnt++;
                we_a = ram_a;
                we_d = ram_wd;
            end
            if (ram_a !== disp_ram_a) disp_mis++;
            done_busy = busy;
            // Pulse at k==1 lands while still idle and must be ignored.
            isa_op_enable = (k == 3 + j) || (k == 1);
            disp_ram_a    = {1'b1, 18'($urandom)};
        end
        bus_memr_l    = 1'b1;
        bus_memw_l    = 1'b1;
        isa_op_enable = 1'b0;
        idle_ok       = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!ram_we_l) we_cnt++;
            if (!busy) begin
                idle_ok = 1'b1;
                break;
            end
        end
        bus_mem_cs = 1'b0;
    endtask

    task automatic apply(input string nm, input bit r, input bit w, input logic [14:0] a,
                         input logic [7:0] d, input int j, input int exp_rdy, input int exp_we,
                         input logic [18:0] exp_a, input logic [7:0] exp_out);
        int rdy_low, we_cnt, disp_mis;
        logic [18:0] we_a;
        logic [7:0] we_d;
        bit done_busy, idle_ok;
        run_xact(r, w, a, d, j, rdy_low, we_cnt, disp_mis, we_a, we_d, done_busy, idle_ok);
        check({nm, ".rdy_low"}, 32'(rdy_low), 32'(exp_rdy));
        check({nm, ".we_cycles"}, 32'(we_cnt), 32'(exp_we));
        if (exp_we == 1) begin
            check({nm, ".ram_a"}, 32'(we_a), 32'(exp_a));
            check({nm, ".ram_wd"}, 32'(we_d), 32'(d));
        end
        check({nm, ".cpu_cycles"}, 32'(disp_mis), (j < Timeout) ? 32'd1 : 32'd0);
        check({nm, ".bus_out"}, 32'(bus_out_mem), 32'(exp_out));
        check({nm, ".held_done"}, 32'(done_busy), 32'd1);
        check({nm, ".idle"}, 32'(idle_ok), 32'd1);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [14:0] a;
        logic [7:0]  d;
        int          j;
        int          rdy;
        int          we;
        logic [18:0] ram_a;
        logic [7:0]  out;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_we, n_busy;
        tbl[0] = '{1'b0, 1'b1, 15'h0010, 8'h41, 3,  5,  1, 19'h00010, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 15'h4005, 8'hC3, 0,  2,  1, 19'h00005, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 15'h1FFF, 8'h00, 2,  6,  0, 19'h00000, 8'h5A};
        tbl[3] = '{1'b1, 1'b0, 15'h0005, 8'h00, 39, 43, 0, 19'h00000, 8'hC3};
        tbl[4] = '{1'b1, 1'b0, 15'h0123, 8'h00, 45, 40, 0, 19'h00000, 8'hFF};
        tbl[5] = '{1'b0, 1'b1, 15'h0200, 8'h77, 40, 40, 0, 19'h00000, 8'hFF};
        tbl[6] = '{1'b1, 1'b1, 15'h0300, 8'h99, 1,  3,  1, 19'h00300, 8'hFF};
        tbl[7] = '{1'b1, 1'b0, 15'h0300, 8'h00, 5,  9,  0, 19'h00000, 8'h99};

        for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
        ref_mem[15'h1FFF] = 8'h5A;
        model_out = 8'h00;

        reset         = 1'b1;
        bus_a         = '0;
        bus_d         = '0;
        bus_memr_l    = 1'b1;
        bus_memw_l    = 1'b1;
        bus_mem_cs    = 1'b0;
        isa_op_enable = 1'b0;
        disp_ram_a    = 19'h4ABCD;
        repeat (3) @(negedge clk);
        check("reset.bus_rdy", 32'(bus_rdy), 32'd1);
        check("reset.ram_we_l", 32'(ram_we_l), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.bus_out", 32'(bus_out_mem), 32'd0);
        check("reset.ram_wd", 32'(ram_wd), 32'd0);
        check("reset.ram_a", 32'(ram_a), 32'h4ABCD);
        bus_mem_cs = 1'b1;
        bus_memr_l = 1'b0;
        #1;
        check("dir.read", 32'(bus_dir_mem), 32'd1);
        bus_memr_l = 1'b1;
        bus_mem_cs = 1'b0;
        #1;
        check("dir.idle", 32'(bus_dir_mem), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].j,
                  tbl[i].rdy, tbl[i].we, tbl[i].ram_a, tbl[i].out);
            if (tbl[i].we == 1) ref_mem[tbl[i].ram_a[14:0]] = tbl[i].d;
            model_out = tbl[i].out;
        end

        // Random transactions against the transaction-level model.
        for (int i = 0; i < 30; i++) begin
            int sel, j, exp_rdy, exp_we;
            bit r, w, acc;
            logic [14:0] a, ma;
            logic [7:0] d;
            sel = int'($urandom_range(0, 2));
            r   = (sel != 1);
            w   = (sel != 0);
            a   = 15'($urandom);
            d   = 8'($urandom);
            j   = int'($urandom_range(0, 45));
            ma  = a & Mask;
            acc = (j < Timeout);
            exp_rdy = !acc ? Timeout : (w ? j + 2 : j + 4);
            exp_we  = (acc && w) ? 1 : 0;
            if (w) begin
                if (acc) ref_mem[ma] = d;
            end else begin
                model_out = acc ? ref_mem[ma] : 8'hFF;
            end
            apply($sformatf("rnd%0d", i), r, w, a, d, j, exp_rdy, exp_we, {4'h0, ma},
                  model_out);
        end

        // Reset while waiting for a slot aborts the write without a clock edge.
        @(negedge clk);
        bus_a      = 15'h0042;
        bus_d      = 8'hE7;
        bus_mem_cs = 1'b1;
        bus_memw_l = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        check("rst_mid.rdy_before", 32'(bus_rdy), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid.bus_rdy", 32'(bus_rdy), 32'd1);
        check("rst_mid.ram_we_l", 32'(ram_we_l), 32'd1);
        check("rst_mid.busy", 32'(busy), 32'd0);
        bus_memw_l = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_we   = 0;
        n_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!ram_we_l) n_we++;
            if (busy) n_busy++;
            isa_op_enable = 1'b1;
        end
        isa_op_enable = 1'b0;
        check("rst_mid.no_write", 32'(n_we), 32'd0);
        check("rst_mid.stays_idle", 32'(n_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
